vc_pop_arbiter: RTL and testbench

//  Read side of the two virtual-channel FIFOs (VC0, VC1) in the transmit path. Pops words from the

---
 rtl/vc_pkg.sv | 15 +
 rtl/vc_wrr_grant.sv | 31 +++
 rtl/vc_pop_arbiter.sv | 105 ++++++++++
 tb/tb_vc_pop_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the VC pop arbiter: FSM encodings and default widths.
package vc_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  // Wide enough for any VC0 weight in 1..15.
  localparam int WRR_CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2,
    ST_ERROR  = 2'd3
  } vc_state_e;

endpackage

// File: rtl/vc_wrr_grant.sv
// Weighted round-robin grant between VC0 and VC1. VC0 wins up to
// VC0_WEIGHT times in a row whenever VC1 also has data.
module vc_wrr_grant
  import vc_pkg::*;
#(
  parameter int VC0_WEIGHT = 3
) (
  input  logic              en,
  input  logic              empty_vc0,
  input  logic              empty_vc1,
  input  logic [WRR_CW-1:0] wrr_cnt,
  output logic [1:0]        grant,
  output logic [WRR_CW-1:0] wrr_cnt_nxt
);

  localparam logic [WRR_CW-1:0] W = WRR_CW'(VC0_WEIGHT);

  // One-hot grant plus next counter value; counter saturates at the weight.
  always_comb begin
    grant       = 2'b00;
    wrr_cnt_nxt = wrr_cnt;
    if (en && !empty_vc0 && (empty_vc1 || (wrr_cnt < W))) begin
      grant       = 2'b01;
      wrr_cnt_nxt = (wrr_cnt >= W) ? W : wrr_cnt + 1'b1;
    end else if (en && !empty_vc1) begin
      grant       = 2'b10;
      wrr_cnt_nxt = '0;
    end
  end

endmodule

// File: rtl/vc_pop_arbiter.sv
// Read side of the VC0/VC1 FIFO pair: pops with weighted priority and
// steers each word into D0 or D1 by its destination bit.
module vc_pop_arbiter
  import vc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_vc0,
  input  logic                  empty_vc1,
  input  logic                  error_vc0,
  input  logic                  error_vc1,
  input  logic [DATA_WIDTH-1:0] data_vc0,
  input  logic [DATA_WIDTH-1:0] data_vc1,
  input  logic                  almost_full_d0,
  input  logic                  almost_full_d1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic [DATA_WIDTH-1:0] data_d0,
  output logic [DATA_WIDTH-1:0] data_d1,
  output logic                  error_out,
  output logic [1:0]            state
);

  vc_state_e         st_q, st_d;
  logic [WRR_CW-1:0] wrr_q, wrr_d;
  logic [1:0]        grant;
  logic              pop_en;
  logic              rd_valid_q, rd_sel_q;
  logic [DATA_WIDTH-1:0] word;
  logic              dest;
  logic              af_any;

  assign af_any = almost_full_d0 | almost_full_d1;
  assign state  = st_q;

  // Destination is unknown before the read, so either almost_full blocks a pop.
  assign pop_en = reset && (st_q == ST_ACTIVE) && !af_any;

  vc_wrr_grant #(.VC0_WEIGHT(VC0_WEIGHT)) u_grant (
    .en          (pop_en),
    .empty_vc0   (empty_vc0),
    .empty_vc1   (empty_vc1),
    .wrr_cnt     (wrr_q),
    .grant       (grant),
    .wrr_cnt_nxt (wrr_d)
  );

  assign pop_vc0 = grant[0];
  assign pop_vc1 = grant[1];

  // Read data arrives the cycle after the pop; pick the FIFO that was popped.
  assign word = rd_sel_q ? data_vc1 : data_vc0;
  assign dest = word[DEST_BIT];

  // Next-state logic; an error on either VC overrides everything and is terminal.
  always_comb begin
    st_d = st_q;
    if (error_vc0 || error_vc1) begin
      st_d = ST_ERROR;
    end else begin
      case (st_q)
        ST_IDLE:   if (!init) st_d = ST_ACTIVE;
        ST_ACTIVE: if (af_any) st_d = ST_STALL;
                   else if (init) st_d = ST_IDLE;
        ST_STALL:  if (!af_any) st_d = ST_ACTIVE;
                   else if (init) st_d = ST_IDLE;
        default:   st_d = ST_ERROR;
      endcase
    end
  end

  // State, WRR counter, read pipeline and registered demux outputs.
  // An issued pop always completes its push regardless of state changes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q       <= ST_IDLE;
      wrr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      push_d0    <= 1'b0;
      push_d1    <= 1'b0;
      data_d0    <= '0;
      data_d1    <= '0;
      error_out  <= 1'b0;
    end else begin
      st_q       <= st_d;
      wrr_q      <= wrr_d;
      rd_valid_q <= |grant;
      rd_sel_q   <= grant[1];
      push_d0    <= rd_valid_q && !dest;
      push_d1    <= rd_valid_q && dest;
      data_d0    <= (rd_valid_q && !dest) ? word : '0;
      data_d1    <= (rd_valid_q && dest)  ? word : '0;
      error_out  <= error_out | (st_q == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: FSM/grant vector table plus
// hand-written multi-cycle sequences against a small FIFO stimulus model.
module tb_vc_pop_arbiter;
  import vc_pkg::*;

  localparam int DW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, init = 1'b1;
  logic error_vc0 = 1'b0, error_vc1 = 1'b0;
  logic almost_full_d0 = 1'b0, almost_full_d1 = 1'b0;
  logic empty_vc0, empty_vc1;
  logic [DW-1:0] data_vc0 = '0, data_vc1 = '0;
  logic pop_vc0, pop_vc1, push_d0, push_d1, error_out;
  logic [DW-1:0] data_d0, data_d1;
  logic [1:0] state;

  // Table mode drives empty flags directly; otherwise the FIFO model does.
  logic tbl_mode = 1'b0, t_e0 = 1'b1, t_e1 = 1'b1;
  logic m_e0 = 1'b1, m_e1 = 1'b1;
  logic ld0 = 1'b0, ld1 = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] q0[$], q1[$];

  assign empty_vc0 = tbl_mode ? t_e0 : m_e0;
  assign empty_vc1 = tbl_mode ? t_e1 : m_e1;

  int errors = 0, checks = 0;

  vc_pop_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(4), .VC0_WEIGHT(3)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .error_vc0(error_vc0), .error_vc1(error_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .almost_full_d0(almost_full_d0), .almost_full_d1(almost_full_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .push_d0(push_d0), .push_d1(push_d1),
    .data_d0(data_d0), .data_d1(data_d1),
    .error_out(error_out), .state(state)
  );

  // FIFO model with registered read data and post-edge empty flags.
  always @(posedge clk) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop_vc0 && q0.size() > 0) data_vc0 <= q0.pop_front();
      if (pop_vc1 && q1.size() > 0) data_vc1 <= q1.pop_front();
      if (ld0) q0.push_back(ld_data);
      if (ld1) q1.push_back(ld_data);
    end
    m_e0 <= !reset || (q0.size() == 0);
    m_e1 <= !reset || (q1.size() == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_cyc(input string nm, input logic p0, input logic p1,
                         input logic pu0, input logic pu1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    chk({nm, ".pop_vc0"}, pop_vc0, p0);
    chk({nm, ".pop_vc1"}, pop_vc1, p1);
    chk({nm, ".push_d0"}, push_d0, pu0);
    chk({nm, ".push_d1"}, push_d1, pu1);
    chk({nm, ".data_d0"}, data_d0, d0);
    chk({nm, ".data_d1"}, data_d1, d1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; init = 1'b1; tbl_mode = 1'b0;
    error_vc0 = 1'b0; error_vc1 = 1'b0;
    almost_full_d0 = 1'b0; almost_full_d1 = 1'b0;
    ld0 = 1'b0; ld1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load(input logic vc, input logic [DW-1:0] d);
    ld0 = !vc; ld1 = vc; ld_data = d;
    @(negedge clk);
    ld0 = 1'b0; ld1 = 1'b0;
  endtask

  typedef struct {
    logic rst, ini, e0, e1, er0, er1, af0, af1;
    vc_state_e st;
    logic p0, p1;
  } vec_t;

  vec_t tbl[16];
  logic sel[16];
  logic [DW-1:0] exp_w[16];

  initial begin
    // Row: reset, init, empty0/1, error0/1, af0/1 -> state this cycle, pop0, pop1
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_IDLE,   1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_IDLE,   1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, ST_IDLE,   1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, ST_ACTIVE, 1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, ST_ACTIVE, 1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, ST_ACTIVE, 1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ST_ACTIVE, 1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ST_STALL,  1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_STALL,  1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_ACTIVE, 1'b1,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_IDLE,   1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, ST_IDLE,   1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_ERROR,  1'b0,1'b0};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, ST_ERROR,  1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_ERROR,  1'b0,1'b0};
    tbl[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ST_IDLE,   1'b0,1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #4;
    exp_cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("reset.state", state, ST_IDLE);
    chk("reset.error_out", error_out, 1'b0);

    // FSM / grant table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tbl_mode = 1'b1;
      reset = tbl[i].rst; init = tbl[i].ini;
      t_e0 = tbl[i].e0; t_e1 = tbl[i].e1;
      error_vc0 = tbl[i].er0; error_vc1 = tbl[i].er1;
      almost_full_d0 = tbl[i].af0; almost_full_d1 = tbl[i].af1;
      #4;
      chk($sformatf("tbl%0d.state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d.pop_vc0", i), pop_vc0, tbl[i].p0);
      chk($sformatf("tbl%0d.pop_vc1", i), pop_vc1, tbl[i].p1);
    end

    // Single VC0 stream, routing by bit 4
    do_reset();
    load(1'b0, 6'h05);
    load(1'b0, 6'h12);
    init = 1'b0; #4;
    exp_cyc("t1.c0", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #4; exp_cyc("t1.c1", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #4; exp_cyc("t1.c2", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #4; exp_cyc("t1.c3", 1'b0, 1'b0, 1'b1, 1'b0, 6'h05, '0);
    @(negedge clk); #4; exp_cyc("t1.c4", 1'b0, 1'b0, 1'b0, 1'b1, '0, 6'h12);
    @(negedge clk); #4; exp_cyc("t1.c5", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Weighted arbitration, both FIFOs with 8 words; drain to empty
    do_reset();
    for (int i = 0; i < 8; i++) load(1'b0, DW'(i));
    for (int i = 0; i < 8; i++) load(1'b1, DW'(6'h10 + i));
    sel = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,
            1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b1};
    begin
      int k0, k1;
      k0 = 0; k1 = 0;
      for (int i = 0; i < 16; i++) begin
        if (sel[i]) begin exp_w[i] = DW'(6'h10 + k1); k1++; end
        else        begin exp_w[i] = DW'(k0);         k0++; end
      end
    end
    init = 1'b0; #4;
    chk("t2.c0.state", state, ST_IDLE);
    for (int c = 1; c <= 18; c++) begin
      logic ep0, ep1, eu0, eu1;
      logic [DW-1:0] ed0, ed1, w;
      @(negedge clk); #4;
      ep0 = (c <= 16) && !sel[(c <= 16) ? c-1 : 0];
      ep1 = (c <= 16) &&  sel[(c <= 16) ? c-1 : 0];
      eu0 = 1'b0; eu1 = 1'b0; ed0 = '0; ed1 = '0;
      if (c >= 3) begin
        w = exp_w[c-3];
        if (w[4]) begin eu1 = 1'b1; ed1 = w; end
        else      begin eu0 = 1'b1; ed0 = w; end
      end
      exp_cyc($sformatf("t2.c%0d", c), ep0, ep1, eu0, eu1, ed0, ed1);
    end

    // Back-pressure after a pop: in-flight word completes, stall, resume
    do_reset();
    for (int i = 1; i <= 4; i++) load(1'b0, DW'(i));
    init = 1'b0; #4;
    exp_cyc("t3.c0", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #4; exp_cyc("t3.c1", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); almost_full_d1 = 1'b1; #4;
    exp_cyc("t3.c2", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #4; exp_cyc("t3.c3", 1'b0, 1'b0, 1'b1, 1'b0, 6'h01, '0);
    chk("t3.c3.state", state, ST_STALL);
    @(negedge clk); #4; exp_cyc("t3.c4", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); almost_full_d1 = 1'b0; #4;
    exp_cyc("t3.c5", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t3.c5.state", state, ST_STALL);
    @(negedge clk); #4; exp_cyc("t3.c6", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t3.c6.state", state, ST_ACTIVE);
    @(negedge clk); #4; exp_cyc("t3.c7", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #4; exp_cyc("t3.c8", 1'b1, 1'b0, 1'b1, 1'b0, 6'h02, '0);
    @(negedge clk); #4; exp_cyc("t3.c9", 1'b0, 1'b0, 1'b1, 1'b0, 6'h03, '0);
    @(negedge clk); #4; exp_cyc("t3.c10", 1'b0, 1'b0, 1'b1, 1'b0, 6'h04, '0);
    @(negedge clk); #4; exp_cyc("t3.c11", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Error while streaming from VC1
    do_reset();
    for (int i = 1; i <= 4; i++) load(1'b1, DW'(6'h10 + i));
    init = 1'b0; #4;
    exp_cyc("t4.c0", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); #4; exp_cyc("t4.c1", 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk); error_vc1 = 1'b1; #4;
    exp_cyc("t4.c2", 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk); error_vc1 = 1'b0; #4;
    exp_cyc("t4.c3", 1'b0, 1'b0, 1'b0, 1'b1, '0, 6'h11);
    chk("t4.c3.state", state, ST_ERROR);
    @(negedge clk); #4; exp_cyc("t4.c4", 1'b0, 1'b0, 1'b0, 1'b1, '0, 6'h12);
    chk("t4.c4.error_out", error_out, 1'b1);
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk); #4;
      exp_cyc($sformatf("t4.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      chk($sformatf("t4.c%0d.error_out", c), error_out, 1'b1);
      chk($sformatf("t4.c%0d.state", c), state, ST_ERROR);
    end
    do_reset(); #4;
    chk("t4.post.error_out", error_out, 1'b0);
    chk("t4.post.state", state, ST_IDLE);

    // Reset the cycle after a pop: the in-flight word is dropped
    load(1'b0, 6'h07);
    load(1'b0, 6'h08);
    init = 1'b0; #4;
    chk("t5.c0.state", state, ST_IDLE);
    @(negedge clk); #4; exp_cyc("t5.c1", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); reset = 1'b0; #4;
    exp_cyc("t5.c2", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); reset = 1'b1; init = 1'b1; #4;
    exp_cyc("t5.c3", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("t5.c3.state", state, ST_IDLE);
    chk("t5.c3.error_out", error_out, 1'b0);
    @(negedge clk); #4; exp_cyc("t5.c4", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // init held high with non-empty FIFOs: no pops
    load(1'b0, 6'h01);
    load(1'b1, 6'h11);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #4;
      chk($sformatf("t6.c%0d.empty_vc0", c), empty_vc0, 1'b0);
      exp_cyc($sformatf("t6.c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      chk($sformatf("t6.c%0d.state", c), state, ST_IDLE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
